trace_arbiter: RTL and testbench

- Shares one trace output port between two trace_unit instances (source 0, source 1).
- Each trace_unit emits a one-cycle trace_data_ready strobe with a trace_output record and cannot be stalled.
- The block buffers each source in its own FIFO, drops and counts records on overflow, and drains to a single valid/ready consumer using round-robin arbitration.
- It sits between the trace units and the trace sink (packetiser or off-chip link).

---
 rtl/ryuki_datatypes.sv | 14 +
 rtl/trace_fifo.sv | 50 +++++
 rtl/trace_arbiter.sv | 108 ++++++++++
 tb/tb_trace_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ryuki_datatypes.sv
// Shared trace datatypes: the trace record, the source id type and the drop-counter width.
package ryuki_datatypes;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  tag;
  } trace_output;

  localparam int TRACE_DROP_WIDTH = 16;

  typedef logic trace_src_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous per-source record FIFO with a combinational head and a flush that clears it.
module trace_fifo
  import ryuki_datatypes::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  trace_output              wdata,
  output trace_output              rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  trace_output   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  // Storage carries no reset; only the pointers and level define contents.
  always_ff @(posedge clk) begin
    if (rst && !flush && push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/trace_arbiter.sv
// Two trace sources buffered in private FIFOs, drained round-robin to one valid/ready sink.
module trace_arbiter
  import ryuki_datatypes::*;
#(
  parameter int DEPTH      = 8,
  parameter int DROP_WIDTH = TRACE_DROP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  src0_ready,
  input  trace_output           src0_data,
  input  logic                  src1_ready,
  input  trace_output           src1_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output trace_output           out_data,
  output trace_src_t            out_src,
  output logic [DROP_WIDTH-1:0] drop_count0,
  output logic [DROP_WIDTH-1:0] drop_count1,
  output logic                  idle
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [1:0]            ready_in, push, pop, drop, full, empty;
  trace_output           data_in [2];
  trace_output           head    [2];
  logic [LW-1:0]         lvl     [2];
  logic [DROP_WIDTH-1:0] drop_cnt [2];

  trace_src_t rr_last;
  trace_src_t gsel;
  logic       gvld, load;

  assign ready_in   = {src1_ready, src0_ready};
  assign data_in[0] = src0_data;
  assign data_in[1] = src1_data;

  // Grant goes to the source not served last whenever both have data.
  always_comb begin
    gvld = 1'b0;
    gsel = 1'b0;
    if (!empty[0] && !empty[1]) begin
      gvld = 1'b1;
      gsel = ~rr_last;
    end else if (!empty[0]) begin
      gvld = 1'b1;
      gsel = 1'b0;
    end else if (!empty[1]) begin
      gvld = 1'b1;
      gsel = 1'b1;
    end
  end

  assign load = (!out_valid || out_ready) && !flush;

  for (genvar i = 0; i < 2; i++) begin : g_src
    assign pop[i]  = load && gvld && (gsel == 1'(i));
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign push[i] = enable && ready_in[i] && !flush && (!full[i] || pop[i]);
    assign drop[i] = enable && ready_in[i] && !flush && !push[i];

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (data_in[i]),
      .rdata (head[i]),
      .level (lvl[i]),
      .full  (full[i]),
      .empty (empty[i])
    );

    always_ff @(posedge clk) begin
      if (!rst)                          drop_cnt[i] <= '0;
      else if (drop[i] && ~&drop_cnt[i]) drop_cnt[i] <= drop_cnt[i] + 1'b1;
    end
  end

  // rr_last=1 after reset/flush so source 0 wins the first contested grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      rr_last   <= 1'b1;
    end else if (flush) begin
      out_valid <= 1'b0;
      rr_last   <= 1'b1;
    end else if (load) begin
      out_valid <= gvld;
      if (gvld) begin
        out_data <= head[gsel];
        out_src  <= gsel;
        rr_last  <= gsel;
      end
    end
  end

  assign drop_count0 = drop_cnt[0];
  assign drop_count1 = drop_cnt[1];
  assign idle        = (lvl[0] == '0) && (lvl[1] == '0) && !out_valid;

endmodule

// File: tb/tb_trace_arbiter.sv
// Directed and random stimulus for trace_arbiter against a queue-based reference model.
module tb_trace_arbiter;
  import ryuki_datatypes::*;

  localparam int DEPTH = 8;
  localparam int DW    = 4;
  localparam int SAT   = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst, enable, flush, src0_ready, src1_ready, out_ready;
  trace_output   src0_data, src1_data, out_data;
  logic          out_valid, idle;
  trace_src_t    out_src;
  logic [DW-1:0] drop_count0, drop_count1;

  always #5 clk = ~clk;

  trace_arbiter #(.DEPTH(DEPTH), .DROP_WIDTH(DW)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .flush       (flush),
    .src0_ready  (src0_ready),
    .src0_data   (src0_data),
    .src1_ready  (src1_ready),
    .src1_data   (src1_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_src     (out_src),
    .drop_count0 (drop_count0),
    .drop_count1 (drop_count1),
    .idle        (idle)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: one queue per source, the output slot, last-served source.
  trace_output q0[$], q1[$];
  bit          mv;
  trace_output md;
  bit          ms;
  bit          last;
  int          d0, d1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic trace_output rnd_rec();
    trace_output r;
    r.pc    = $urandom;
    r.instr = $urandom;
    r.tag   = 8'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    q0.delete(); q1.delete();
    mv = 0; md = '0; ms = 0; last = 1; d0 = 0; d1 = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 128'(out_valid), 128'(mv));
    if (mv) begin
      chk({tag, ".data"}, 128'(out_data), 128'(md));
      chk({tag, ".src"},  128'(out_src),  128'(ms));
    end
    chk({tag, ".idle"},  128'(idle), 128'(q0.size() == 0 && q1.size() == 0 && !mv));
    chk({tag, ".drop0"}, 128'(drop_count0), 128'(d0));
    chk({tag, ".drop1"}, 128'(drop_count1), 128'(d1));
  endtask

  task automatic step(input string tag, input bit en, input bit fl,
                      input bit r0, input trace_output a0,
                      input bit r1, input trace_output a1, input bit ordy);
    enable = en; flush = fl; src0_ready = r0; src0_data = a0;
    src1_ready = r1; src1_data = a1; out_ready = ordy;
    @(posedge clk);
    if (fl) begin
      q0.delete(); q1.delete(); mv = 0; last = 1;
    end else begin
      if (!mv || ordy) begin
        if (q0.size() != 0 && (q1.size() == 0 || last == 1)) begin
          md = q0.pop_front(); ms = 0; mv = 1; last = 0;
        end else if (q1.size() != 0) begin
          md = q1.pop_front(); ms = 1; mv = 1; last = 1;
        end else mv = 0;
      end
      if (en && r0) begin
        if (q0.size() < DEPTH) q0.push_back(a0);
        else if (d0 < SAT) d0++;
      end
      if (en && r1) begin
        if (q1.size() < DEPTH) q1.push_back(a1);
        else if (d1 < SAT) d1++;
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    trace_output z;
    z = '0;
    enable = 1; flush = 0; src0_ready = 0; src1_ready = 0; out_ready = 0;
    src0_data = '0; src1_data = '0;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset.valid", 128'(out_valid), 128'(0));
    chk("reset.data",  128'(out_data),  128'(0));
    chk("reset.src",   128'(out_src),   128'(0));
    chk("reset.idle",  128'(idle),      128'(1));
    chk("reset.drop0", 128'(drop_count0), 128'(0));
    chk("reset.drop1", 128'(drop_count1), 128'(0));
    rst = 1;

    // Single source, one record per cycle, consumer always ready.
    for (int i = 0; i < 3; i++) step("single", 1, 0, 1, rnd_rec(), 0, z, 1);
    for (int i = 0; i < 3; i++) step("single.tail", 1, 0, 0, z, 0, z, 1);

    // Round-robin: preload both sources, then release the consumer.
    for (int i = 0; i < 3; i++) step("rr.load", 1, 0, 1, rnd_rec(), 1, rnd_rec(), 0);
    for (int i = 0; i < 8; i++) step("rr.drain", 1, 0, 0, z, 0, z, 1);

    // Overflow on source 1 with the output slot already occupied.
    step("ovf.pre", 1, 0, 1, rnd_rec(), 0, z, 0);
    step("ovf.pre", 1, 0, 0, z, 0, z, 0);
    for (int i = 0; i < 12; i++) step("ovf", 1, 0, 0, z, 1, rnd_rec(), 0);
    chk("ovf.drop1_is_4", 128'(drop_count1), 128'(4));
    for (int i = 0; i < 20; i++) step("sat", 1, 0, 0, z, 1, rnd_rec(), 0);
    chk("sat.drop1", 128'(drop_count1), 128'(SAT));
    for (int i = 0; i < 12; i++) step("ovf.drain", 1, 0, 0, z, 0, z, 1);

    // Full FIFO0 accepts a strobe when its head leaves in the same cycle.
    for (int i = 0; i < 9; i++) step("full.fill", 1, 0, 1, rnd_rec(), 0, z, 0);
    step("full.pushpop", 1, 0, 1, rnd_rec(), 0, z, 1);
    chk("full.drop0", 128'(drop_count0), 128'(0));
    step("full.hold", 1, 0, 0, z, 0, z, 0);
    for (int i = 0; i < 11; i++) step("full.drain", 1, 0, 0, z, 0, z, 1);

    // Flush with both FIFOs loaded and strobes present.
    for (int i = 0; i < 6; i++) step("fl.load", 1, 0, 1, rnd_rec(), 1, rnd_rec(), 0);
    step("fl.flush", 1, 1, 1, rnd_rec(), 1, rnd_rec(), 1);
    chk("fl.idle", 128'(idle), 128'(1));
    for (int i = 0; i < 3; i++) step("en0", 0, 0, 1, rnd_rec(), 1, rnd_rec(), 1);
    chk("en0.idle", 128'(idle), 128'(1));

    // Random traffic including occasional flush and intake disable.
    for (int i = 0; i < 800; i++) begin
      step("rand",
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 1) == 1, rnd_rec(),
           $urandom_range(0, 2) != 0, rnd_rec(),
           $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 20; i++) step("rand.drain", 1, 0, 0, z, 0, z, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
